seg_display_scan: RTL
=====================

// Module: seg_display_scan
// PURPOSE
//  Downstream consumer of the timekeeping block: takes BCD hour/minute digits and drives a
//  4-digit multiplexed common-anode 7-segment display (HH:MM). Scans one digit per slot,
//  blanks anodes at each slot start (anti-ghosting), blinks the colon, and blinks the field
//  being adjusted. Sits between the time counter outputs and the board pins.
// PARAMETERS
//  SCAN_DIV     100_000  clk cycles per digit slot (>= GUARD+2)
//  GUARD        16       cycles at start of each slot with all anodes off (< SCAN_DIV)
//  BLINK_SLOTS  250      slot ticks per blink half-period
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  h1         in   2  hour tens digit (BCD)
//  h2         in   4  hour units digit (BCD)
//  m1         in   3  minute tens digit (BCD)
//  m2         in   4  minute units digit (BCD)
//  adjust     in   1  1 = time-adjust mode active
//  adj_field  in   1  field being adjusted: 0 = minutes, 1 = hours
//  an         out  4  anode enables, active-low; an[0] = rightmost digit
//  seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp         out  1  decimal point (colon), active-low
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst). All outputs registered.
//  - Reset: prescaler=0, idx=0, blink_cnt=0, blink_phase=0, adjust_q=0; an=4'b1111,
//    seg=7'h7F, dp=1. rst mid-scan takes effect at the next edge regardless of state.
//  - Prescaler counts 0..SCAN_DIV-1 and wraps; tick = (prescaler==SCAN_DIV-1).
//  - On tick: idx <= idx+1 (2-bit, 3->0 wraps naturally).
//  - Digit map: idx0=m2/an 1110, idx1=m1/an 1101, idx2=h2/an 1011, idx3=h1/an 0111.
//  - Each clock, outputs register from current state: an = all 1s while prescaler < GUARD,
//    else one-hot-low for idx. seg/dp reflect idx at all times (only anodes blanked by guard).
//    Latency: 1 clk from state to pins.
//  - Decode (active-low gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//    5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; any value >9 -> 0111111 (dash).
//    Narrow inputs zero-extended to 4 bits before decode.
//  - Blink: on tick, blink_cnt increments; at BLINK_SLOTS-1 it wraps to 0 and blink_phase
//    toggles. adjust_q <= adjust each clk; adjust rising edge (adjust & ~adjust_q) forces
//    blink_cnt=0, blink_phase=0 (field visible first); rising edge wins over simultaneous tick.
//  - Field blink: adjust=1 & blink_phase=1 -> seg=7'h7F for idx2/idx3 (adj_field=1) or
//    idx0/idx1 (adj_field=0); anode timing unchanged. adjust=0 -> no field blanking.
//  - Colon: dp=0 only on idx2 and only when (adjust | ~blink_phase); dp=1 elsewhere.
//    Colon steady on in adjust mode, blinks otherwise.
//  - Input digits sampled combinationally into the output register; mid-slot input changes
//    appear on the next clk.
// CONFIGURATION
//  DISP_LEAD_ZERO_BLANK_EN defined: on idx3 with h1==0, seg=7'h7F (hour tens blanked);
//    anode scan still visits idx3. Field-blink rules apply unchanged.
//  Not defined: h1==0 displays '0' (1000000).
// TESTING (bench params SCAN_DIV=8, GUARD=2, BLINK_SLOTS=4)
//  1. rst=1 for 3 clks -> an=1111, seg=7F, dp=1; after release an=1111 for clks with
//     prescaler 0..1, then an=1110.
//  2. 12:34, adjust=0 -> slots in order: an1110/seg0011001, an1101/0110000,
//     an1011/0100100 with dp=0 in phase0 and dp=1 in phase1, an0111/1111001.
//  3. adjust 0->1, adj_field=1 -> first 32 clks hours visible; next 32 clks idx2/idx3
//     seg=7F, minutes still shown, dp=0 on idx2 throughout.
//  4. h2=4'hA -> idx2 seg=0111111; m1=3'd7 -> idx1 seg=1111000.
//  5. rst asserted while idx=2 at prescaler=5 -> next clk reset values; scan restarts idx0,
//     blink_phase=0.
//  6. DISP_LEAD_ZERO_BLANK_EN, time 05:00 -> idx3 seg=7F, an=0111 still asserted; without
//     macro idx3 seg=1000000.

Source files
------------

// File: rtl/seg_display_scan.sv
// -----------------------------------------------------------------------------
// seg_display_scan
//
// Drives a 4-digit multiplexed common-anode 7-segment display showing HH:MM
// from BCD hour/minute digits. One digit is lit per scan slot. Anodes are held
// off for the first GUARD cycles of every slot so the previous digit's
// segments never ghost onto the next anode. The colon (dp on the hour-units
// digit) blinks in normal mode and is steady while adjusting. The field being
// adjusted blinks, starting with a visible half-period.
//
// Optional build macro:
//   DISP_LEAD_ZERO_BLANK_EN - blank the hour-tens digit when it is zero
//                             (anode still scanned).
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous, active-high reset
//   h1         in   2  hour tens digit (BCD)
//   h2         in   4  hour units digit (BCD)
//   m1         in   3  minute tens digit (BCD)
//   m2         in   4  minute units digit (BCD)
//   adjust     in   1  1 = time-adjust mode active
//   adj_field  in   1  field being adjusted: 0 = minutes, 1 = hours
//   an         out  4  anode enables, active-low, an[0] = rightmost digit
//   seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  1  decimal point / colon, active-low
// -----------------------------------------------------------------------------
module seg_display_scan #(
    parameter int SCAN_DIV    = 100_000,
    parameter int GUARD       = 16,
    parameter int BLINK_SLOTS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] h1,
    input  logic [3:0] h2,
    input  logic [2:0] m1,
    input  logic [3:0] m2,
    input  logic       adjust,
    input  logic       adj_field,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(BLINK_SLOTS + 1);

    logic [PW-1:0] prescaler_reg, prescaler_next;
    logic [1:0]    idx_reg, idx_next;
    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          blink_phase_reg, blink_phase_next;
    logic          adjust_q_reg;
    logic [3:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;

    logic       tick;
    logic       adjust_rise;
    logic       guard;
    logic [3:0] an_scan;
    logic [3:0] digit;
    logic       field_hit;

    // Active-low gfedcba; anything outside 0..9 shows a dash.
    function automatic logic [6:0] decode7(input logic [3:0] d);
        case (d)
            4'd0:    decode7 = 7'b1000000;
            4'd1:    decode7 = 7'b1111001;
            4'd2:    decode7 = 7'b0100100;
            4'd3:    decode7 = 7'b0110000;
            4'd4:    decode7 = 7'b0011001;
            4'd5:    decode7 = 7'b0010010;
            4'd6:    decode7 = 7'b0000010;
            4'd7:    decode7 = 7'b1111000;
            4'd8:    decode7 = 7'b0000000;
            4'd9:    decode7 = 7'b0010000;
            default: decode7 = 7'b0111111;
        endcase
    endfunction

    assign tick        = (prescaler_reg == PW'(SCAN_DIV - 1));
    assign adjust_rise = adjust & ~adjust_q_reg;
    assign guard       = (prescaler_reg < PW'(GUARD));

    // One-hot-low anode pattern for the digit currently being scanned.
    for (genvar gi = 0; gi < 4; gi++) begin : g_anode
        assign an_scan[gi] = (idx_reg != 2'(gi));
    end

    // Hours occupy idx2/idx3 (idx_reg[1]=1), minutes idx0/idx1.
    assign field_hit = adj_field ? idx_reg[1] : ~idx_reg[1];

    always_comb begin
        digit = m2;
        case (idx_reg)
            2'd0: digit = m2;
            2'd1: digit = {1'b0, m1};
            2'd2: digit = h2;
            2'd3: digit = {2'b00, h1};
            default: digit = m2;
        endcase
    end

    always_comb begin
        prescaler_next   = tick ? '0 : prescaler_reg + 1'b1;
        idx_next         = tick ? idx_reg + 2'd1 : idx_reg;
        blink_cnt_next   = blink_cnt_reg;
        blink_phase_next = blink_phase_reg;

        // A fresh entry into adjust mode restarts the blink so the field is
        // visible first; this takes priority over a coincident slot tick.
        if (adjust_rise) begin
            blink_cnt_next   = '0;
            blink_phase_next = 1'b0;
        end else if (tick) begin
            if (blink_cnt_reg == BW'(BLINK_SLOTS - 1)) begin
                blink_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + 1'b1;
            end
        end

        // Only anodes are blanked by the guard window; seg/dp track idx.
        an_next  = guard ? 4'b1111 : an_scan;
        seg_next = decode7(digit);
`ifdef DISP_LEAD_ZERO_BLANK_EN
        if (idx_reg == 2'd3 && h1 == 2'd0)
            seg_next = 7'h7F;
`endif
        if (adjust && blink_phase_reg && field_hit)
            seg_next = 7'h7F;
        dp_next = ~((idx_reg == 2'd2) && (adjust || !blink_phase_reg));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_reg   <= '0;
            idx_reg         <= 2'd0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            adjust_q_reg    <= 1'b0;
            an_reg          <= 4'b1111;
            seg_reg         <= 7'h7F;
            dp_reg          <= 1'b1;
        end else begin
            prescaler_reg   <= prescaler_next;
            idx_reg         <= idx_next;
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
            adjust_q_reg    <= adjust;
            an_reg          <= an_next;
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = dp_reg;

endmodule
